// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-triggered fixed-priority interrupt controller with mask/status registers
module interrupt_controller #(
    parameter int                DBITS     = 32,
    parameter int                NUM_SRC   = 4,
    parameter logic [DBITS-1:0]  MASK_ADDR = 32'hF0000800,
    parameter logic [DBITS-1:0]  STAT_ADDR = 32'hF0000804
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq,
    output logic [NUM_SRC-1:0] devAck,
    output logic               inta,
    output logic [DBITS-1:0]   idn,
    input  logic               intAck,
    input  logic               eoi,
    input  logic [DBITS-1:0]   memAddrBus,
    input  logic               weBus,
    input  logic               reBus,
    input  logic [DBITS-1:0]   dataBusIn,
    output logic [DBITS-1:0]   dataBusOut
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_REQ     = 2'b01;
    localparam logic [1:0] ST_SERVICE = 2'b10;

    logic [1:0]         state;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [3:0]         idn_r;

    logic [NUM_SRC-1:0] irq_edge;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] ack_sel;
    logic [NUM_SRC-1:0] clr;
    logic [3:0]         winner;
    logic               wr_mask;
    logic               wr_stat;
    logic               accept;
    logic               unused_data;

    assign irq_edge = irq & ~irq_prev;
    assign eligible = pending & mask;
    assign wr_mask  = weBus && (memAddrBus == MASK_ADDR);
    assign wr_stat  = weBus && (memAddrBus == STAT_ADDR);
    assign accept   = (state == ST_REQ) && intAck;
    assign idn      = {{(DBITS-4){1'b0}}, idn_r};

    // Only the low NUM_SRC write-data bits map onto register fields.
    assign unused_data = ^dataBusIn[DBITS-1:NUM_SRC];

    // Lowest-index eligible source wins; one-hot decode of the offered source.
    always_comb begin
        winner  = '0;
        ack_sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 4'(i);
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_sel[i] = (idn_r == 4'(i));
        end
        clr = (wr_stat ? dataBusIn[NUM_SRC-1:0] : '0) | (accept ? ack_sel : '0);
    end

    // Edge capture, pending/mask registers; a new edge overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '0;
        end else begin
            irq_prev <= irq;
            pending  <= (pending & ~clr) | irq_edge;
            if (wr_mask) mask <= dataBusIn[NUM_SRC-1:0];
        end
    end

    // Delivery FSM: offer one source, hold it until taken, then wait for RETI.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            inta   <= 1'b0;
            idn_r  <= '0;
            devAck <= '0;
        end else begin
            devAck <= '0;
            case (state)
                ST_IDLE: begin
                    if (eligible != '0) begin
                        state <= ST_REQ;
                        idn_r <= winner;
                        inta  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (intAck) begin
                        state  <= ST_SERVICE;
                        inta   <= 1'b0;
                        devAck <= ack_sel;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Combinational register readback; idle bus reads as zero.
    always_comb begin
        dataBusOut = '0;
        if (reBus && memAddrBus == MASK_ADDR) begin
            dataBusOut[NUM_SRC-1:0] = mask;
        end else if (reBus && memAddrBus == STAT_ADDR) begin
            dataBusOut[NUM_SRC-1:0] = pending;
            dataBusOut[19:16]       = idn_r;
            dataBusOut[25:24]       = state;
        end
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Collects edge-triggered interrupt requests from up to NUM_SRC peripheral devices, latches them as pending, and presents one at a time to the CPU through the CPU's inta/idn inputs, using a fixed-priority scheduler. It sits between the device irq lines and the CPU core. It is also a memory-mapped slave on the CPU data bus, with a mask register and a status register. It serialises delivery: no new interrupt is offered until the CPU signals end-of-interrupt (RETI).

## Interface
- DBITS, 32, data/address bus width
- NUM_SRC, 4, number of interrupt sources (1..16)
- MASK_ADDR, 32'hF0000800, byte address of mask register (R/W)
- STAT_ADDR, 32'hF0000804, byte address of status register (R, W1C on pending bits)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- irq  in  NUM_SRC  device request lines, synchronous to clk
- devAck  out  NUM_SRC  one-cycle pulse to the device whose interrupt the CPU accepted
- inta  out  1  interrupt request to CPU
- idn  out  DBITS  winning source index, zero-extended
- intAck  in  1  one-cycle pulse from CPU: interrupt taken
- eoi  in  1  one-cycle pulse from CPU: RETI executed
- memAddrBus  in  DBITS  bus address
- weBus  in  1  bus write enable
- reBus  in  1  bus read enable
- dataBusIn  in  DBITS  write data from CPU
- dataBusOut  out  DBITS  read data; all zeros unless a register is selected by a read

## Operation
- Edge detect: irqPrev register. A source's edge is irq & ~irqPrev. An edge sets pending[i].
- Pending is cleared by delivery (accepted ack) or by a W1C write to STAT_ADDR. If a set and a clear hit the same bit in the same cycle, the set wins.
- Eligible = pending & mask. Winner = lowest eligible index (index 0 has highest priority).
- FSM states:
  - IDLE (00): if eligible is nonzero, go to REQ. In that transition, latch idn = winner and set inta = 1.
  - REQ (01): inta is held at 1 and idn is held stable. On intAck, go to SERVICE: clear pending[idn], pulse devAck[idn] for one cycle, set inta = 0.
  - SERVICE (10): wait for eoi, then go to IDLE.
- While in REQ, a masking write or a W1C write does not retract inta. The offered interrupt is still delivered on intAck.
- intAck outside REQ is ignored. eoi outside SERVICE is ignored.
- Mask register write: at MASK_ADDR with weBus=1, mask <= dataBusIn[NUM_SRC-1:0]. Read returns the mask, zero-extended.
- Status register read layout: bits [NUM_SRC-1:0] = pending, [19:16] = idn[3:0] (current or last delivered source), [25:24] = FSM state.
- Status W1C: writing 1s at STAT_ADDR clears those pending bits.
- Other addresses: no effect on registers; dataBusOut = 0.
- Reset values: state=IDLE, pending=0, mask=0, irqPrev=0, inta=0, idn=0, devAck=0, dataBusOut=0.
- Reset asserted mid-REQ or mid-SERVICE returns the block to IDLE on that edge. Any request in flight is dropped.

## Timing
- irq rising at cycle n (sampled at edge n): pending is set after edge n.
- With the source unmasked, inta=1 after edge n+1. Latency from irq edge to inta is 2 cycles.
- intAck at edge m (in REQ): after edge m, inta=0 and devAck pulses during cycle m+1 only.
- eoi at edge k (in SERVICE): state is IDLE after edge k. The next inta can be asserted after edge k+1 at the earliest.
- Bus reads are combinational on memAddrBus/reBus, so data is valid in the same cycle. Writes take effect at the next edge.
- A level-high irq with no new edge does not re-pend the source.

## Test plan
- Reset, then write mask=0xF. Pulse irq[2] high at cycle 5 -> pending[2]=1 after edge 5, inta=1 and idn=2 after edge 6. intAck -> devAck=4'b0100 for 1 cycle, inta=0, status state=10. eoi -> state=00.
- Mask=0xF. irq[3] and irq[1] rise together -> idn=1 first. After intAck and eoi, idn=3 is offered 2 cycles after eoi.
- Mask=0x0. Pulse irq[0] -> pending=0001, inta stays 0. Write mask=0x1 -> inta=1 the cycle after the write edge.
- In REQ with idn=2, write mask=0 -> inta stays 1. intAck still pulses devAck[2] and clears pending[2].
- In SERVICE, a new edge on irq[0] -> pending[0]=1 but no inta until eoi. Also assert intAck during SERVICE -> no effect. Write STAT_ADDR with 0x1 while irq[0] edge coincides -> pending[0] stays 1.
- In REQ, assert reset for one cycle -> inta=0, idn=0, pending=0, mask=0, status reads 0.
